// File: rtl/param_stack_if.sv
// Bus bundle for param_stack: push/pop/clear requests in, popped data, peek and occupancy flags out.
interface param_stack_if #(
  parameter int WordSize    = 8,
  parameter int AddressSize = 3
);
  logic [WordSize-1:0]  Data_In;
  logic                 push;
  logic                 pop;
  logic                 clear;
  logic [WordSize-1:0]  Data_Out;
  logic                 Valid;
  logic [WordSize-1:0]  Top;
  logic [AddressSize:0] Count;
  logic                 Full;
  logic                 Empty;
  logic                 AlmostFull;
  logic                 Error;

  modport master (
    output Data_In, push, pop, clear,
    input  Data_Out, Valid, Top, Count, Full, Empty, AlmostFull, Error
  );

  modport slave (
    input  Data_In, push, pop, clear,
    output Data_Out, Valid, Top, Count, Full, Empty, AlmostFull, Error
  );
endinterface

// File: rtl/param_stack.sv
// LIFO stack of 2^AddressSize words with replace/bypass on simultaneous push+pop.
module param_stack #(
  parameter int WordSize        = 8,
  parameter int AddressSize     = 3,
  parameter int AlmostFullLevel = (1 << AddressSize) - 2
) (
  input logic        Clk,
  input logic        RstN,
  param_stack_if.slave bus
);
  localparam int Depth = 1 << AddressSize;
  localparam logic [AddressSize:0] CountOne   = (AddressSize+1)'(1);
  localparam logic [AddressSize:0] DepthCount = CountOne << AddressSize;
  localparam logic [AddressSize:0] AfLevel    = (AddressSize+1)'(AlmostFullLevel);

  logic [WordSize-1:0]    mem [Depth];
  logic [AddressSize:0]   count_q;
  logic [WordSize-1:0]    data_out_q;
  logic                   valid_q;
  logic                   error_q;
  logic [AddressSize-1:0] top_idx;
  logic                   full;
  logic                   empty;

  // Flags derive from the count register so they can never disagree with it.
  assign full    = (count_q == DepthCount);
  assign empty   = (count_q == '0);
  assign top_idx = count_q[AddressSize-1:0] - AddressSize'(1);

  assign bus.Count      = count_q;
  assign bus.Full       = full;
  assign bus.Empty      = empty;
  assign bus.AlmostFull = (count_q >= AfLevel);
  assign bus.Data_Out   = data_out_q;
  assign bus.Valid      = valid_q;
  assign bus.Error      = error_q;
  assign bus.Top        = empty ? '0 : mem[top_idx];

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      if (bus.clear) begin
        count_q <= '0;
      end else begin
        unique case ({bus.push, bus.pop})
          2'b10: begin
            if (full) error_q <= 1'b1;
            else      count_q <= count_q + CountOne;
          end
          2'b01: begin
            if (empty) begin
              error_q <= 1'b1;
            end else begin
              data_out_q <= mem[top_idx];
              count_q    <= count_q - CountOne;
              valid_q    <= 1'b1;
            end
          end
          // Simultaneous push+pop swaps the top entry, or passes straight through when empty.
          2'b11: begin
            data_out_q <= empty ? bus.Data_In : mem[top_idx];
            valid_q    <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Storage is deliberately unreset; stale words are hidden once Count is zero.
  always_ff @(posedge Clk) begin
    if (!bus.clear) begin
      if (bus.push && !bus.pop && !full)
        mem[count_q[AddressSize-1:0]] <= bus.Data_In;
      else if (bus.push && bus.pop && !empty)
        mem[top_idx] <= bus.Data_In;
    end
  end
endmodule

// File: tb/tb_param_stack.sv
// Scoreboard bench for param_stack: a behavioural stack model queues expectations, checked after each edge.
module tb_param_stack;
  logic clk;
  logic rst_n;

  param_stack_if #(.WordSize(8), .AddressSize(3)) bus ();

  param_stack #(.WordSize(8), .AddressSize(3), .AlmostFullLevel(6)) dut (
    .Clk (clk),
    .RstN(rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dout;
    logic       valid;
    logic       err;
    logic [3:0] count;
    logic [7:0] top;
    logic       full;
    logic       empty;
    logic       af;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] m_mem [8];
  int         m_count;
  logic [7:0] m_dout;
  int         check_count;
  int         error_count;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic exp_t modelStep(input logic p, input logic q, input logic c, input logic [7:0] d);
    exp_t e;
    e.valid = 1'b0;
    e.err   = 1'b0;
    if (c) begin
      m_count = 0;
    end else if (p && !q) begin
      if (m_count == 8) e.err = 1'b1;
      else begin m_mem[m_count] = d; m_count++; end
    end else if (!p && q) begin
      if (m_count == 0) e.err = 1'b1;
      else begin m_dout = m_mem[m_count-1]; m_count--; e.valid = 1'b1; end
    end else if (p && q) begin
      e.valid = 1'b1;
      if (m_count == 0) m_dout = d;
      else begin m_dout = m_mem[m_count-1]; m_mem[m_count-1] = d; end
    end
    e.dout  = m_dout;
    e.count = 4'(m_count);
    e.top   = (m_count == 0) ? 8'h00 : m_mem[m_count-1];
    e.full  = (m_count == 8);
    e.empty = (m_count == 0);
    e.af    = (m_count >= 6);
    return e;
  endfunction

  task automatic applyStimulus(input logic p, input logic q, input logic c, input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    bus.push    = p;
    bus.pop     = q;
    bus.clear   = c;
    bus.Data_In = d;
    sb_q.push_back(modelStep(p, q, c, d));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      checkOutput("data_out",    32'(bus.Data_Out),   32'(e.dout));
      checkOutput("valid",       32'(bus.Valid),      32'(e.valid));
      checkOutput("error",       32'(bus.Error),      32'(e.err));
      checkOutput("count",       32'(bus.Count),      32'(e.count));
      checkOutput("top",         32'(bus.Top),        32'(e.top));
      checkOutput("full",        32'(bus.Full),       32'(e.full));
      checkOutput("empty",       32'(bus.Empty),      32'(e.empty));
      checkOutput("almost_full", 32'(bus.AlmostFull), 32'(e.af));
      checkOutput("valid_and_error", 32'(bus.Valid & bus.Error), 32'd0);
    end
    bus.push  = 1'b0;
    bus.pop   = 1'b0;
    bus.clear = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_count"},    32'(bus.Count),      32'd0);
    checkOutput({tag, "_data_out"}, 32'(bus.Data_Out),   32'd0);
    checkOutput({tag, "_valid"},    32'(bus.Valid),      32'd0);
    checkOutput({tag, "_error"},    32'(bus.Error),      32'd0);
    checkOutput({tag, "_empty"},    32'(bus.Empty),      32'd1);
    checkOutput({tag, "_full"},     32'(bus.Full),       32'd0);
    checkOutput({tag, "_af"},       32'(bus.AlmostFull), 32'd0);
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    m_count     = 0;
    m_dout      = 8'h00;
    rst_n       = 1'b0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.clear   = 1'b0;
    bus.Data_In = 8'h00;

    #12;
    checkResetState("reset");
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

    // Fill to full, then one overflow attempt.
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'(i * 8'h11));
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h99);
    checkOutput("overflow_top", 32'(bus.Top), 32'h88);

    // Drain, then one underflow attempt.
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("underflow_hold", 32'(bus.Data_Out), 32'h11);

    applyStimulus(1'b1, 1'b0, 1'b0, 8'hA1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hB2);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hC3);
    checkOutput("replace_dout", 32'(bus.Data_Out), 32'hB2);
    checkOutput("replace_top",  32'(bus.Top),      32'hC3);

    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h5A);
    checkOutput("bypass_dout", 32'(bus.Data_Out), 32'h5A);

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h77);
    checkOutput("clear_dout", 32'(bus.Data_Out), 32'h5A);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

    // Asynchronous reset pulsed between edges with entries stored.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'hE0 + i));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetState("async_reset");
    m_count = 0;
    m_dout  = 8'h00;
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

    for (int i = 0; i < 60; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 11) == 0), 8'($urandom_range(0, 255)));

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end
endmodule
